// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Computes the mult/multu/div/divu result when
// the operation starts and holds it internally. A 4-bit counter then runs for a
// fixed number of busy cycles, and HI/LO take the result on the final edge.
// mfhi/mflo are served combinationally. mthi/mtlo write HI/LO directly.
//
// Handshake: start is a one-cycle strobe that is high when an MD operation is
// presented in E, is not cancelled, and the unit is idle. busy is high for
// exactly MULT_CYCLES or DIV_CYCLES cycles, beginning in the cycle after start.
// Each accepted operation produces exactly one HI/LO update, which is skipped
// for a divide by zero.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic        busy_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] res_hi_q, res_lo_q;
  logic        res_wr_q;   // 0 when the pending result must not reach HI/LO (divide by zero)

  logic [31:0] res_hi_d, res_lo_d;
  logic        res_wr_d;
  logic [3:0]  cnt_d;
  logic        is_md;

  assign is_md  = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign start  = is_md && !cancel && !busy_q;
  assign busy   = busy_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign md_out = (md_op == OP_MFHI) ? hi_q :
                  (md_op == OP_MFLO) ? lo_q : 32'h0;

  // Arithmetic for the operation in E. Signed division works on magnitudes so
  // that 0x80000000 / -1 needs no special case and yields 0x80000000 rem 0.
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
  logic        a_neg, b_neg, div_zero;

  always_comb begin
    prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u   = {32'h0, rs_val} * {32'h0, rt_val};
    a_neg    = (md_op == OP_DIV) && rs_val[31];
    b_neg    = (md_op == OP_DIV) && rt_val[31];
    a_mag    = a_neg ? (~rs_val + 32'd1) : rs_val;
    b_mag    = b_neg ? (~rt_val + 32'd1) : rt_val;
    div_zero = (rt_val == 32'h0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    res_hi_d = 32'h0;
    res_lo_d = 32'h0;
    res_wr_d = 1'b1;
    cnt_d    = MULT_N;
    case (md_op)
      OP_MULT:  begin res_hi_d = prod_s[63:32]; res_lo_d = prod_s[31:0]; end
      OP_MULTU: begin res_hi_d = prod_u[63:32]; res_lo_d = prod_u[31:0]; end
      OP_DIV, OP_DIVU: begin
        cnt_d    = DIV_N;
        res_wr_d = !div_zero;
        res_lo_d = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        res_hi_d = a_neg ? (~r_mag + 32'd1) : r_mag;
      end
      default: ;
    endcase
  end

  // Start latch, countdown, completion write-back and mthi/mtlo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= 4'd0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
      res_hi_q <= 32'h0;
      res_lo_q <= 32'h0;
      res_wr_q <= 1'b0;
    end else if (busy_q) begin
      if (cnt_q <= 4'd1) begin
        busy_q <= 1'b0;
        cnt_q  <= 4'd0;
        if (res_wr_q) begin
          hi_q <= res_hi_q;
          lo_q <= res_lo_q;
        end
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end else if (!cancel) begin
      if (md_op == OP_MTHI) hi_q <= rs_val;
      if (md_op == OP_MTLO) lo_q <= rs_val;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed vectors plus random operations. Expected HI/LO
// values come from a 64-bit reference model and are queued at start, then
// popped and compared when busy falls.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        cancel;
  logic [31:0] rs_val, rt_val;
  logic        start, busy;
  logic [31:0] hi, lo, md_out;

  logic [31:0] exp_q[$];
  logic [31:0] hi_m, lo_m;
  int          n_chk  = 0;
  int          n_pass = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .cancel(cancel),
    .rs_val(rs_val), .rt_val(rt_val), .start(start), .busy(busy),
    .hi(hi), .lo(lo), .md_out(md_out)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference model on 64-bit integers.
  task automatic calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = hi_m;
    el = lo_m;
    case (op)
      4'd1: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      4'd2: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; end
      4'd3: if (b != 0) begin
              q = sa / sb; r = sa % sb;
              el = q[31:0]; eh = r[31:0];
            end
      4'd4: if (b != 0) begin el = a / b; eh = a % b; end
      default: ;
    endcase
  endtask

  // Issue one MD operation, count busy cycles, then compare HI/LO.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input bit peek);
    logic [31:0] eh, el;
    int n;
    calc(op, a, b, eh, el);
    @(negedge clk);
    md_op = op; rs_val = a; rt_val = b; cancel = 1'b0;
    #1 check("start_hi", 32'(start), 32'd1);
    exp_q.push_back(eh);
    exp_q.push_back(el);
    @(posedge clk); #1;
    md_op = 4'd0;
    rs_val = $urandom; rt_val = $urandom;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (peek && n == 2) begin
        md_op = 4'd6;
        #1 check("mflo_busy", md_out, lo_m);
        md_op = 4'd1;
        #1 check("start_busy", 32'(start), 32'd0);
        md_op = 4'd0;
      end
      @(posedge clk); #1;
    end
    check("busy_cycles", 32'(n), 32'(exp_cyc));
    if (exp_q.size() >= 2) begin
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      check("hi", hi, eh);
      check("lo", lo, el);
      hi_m = eh;
      lo_m = el;
    end else begin
      check("queue_underflow", 32'(exp_q.size()), 32'd2);
    end
    md_op = 4'd5;
    #1 check("mfhi", md_out, hi_m);
    md_op = 4'd0;
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] v, input logic c);
    @(negedge clk);
    md_op = op; rs_val = v; cancel = c;
    #1 check("start_move", 32'(start), 32'd0);
    @(posedge clk); #1;
    md_op = 4'd0; cancel = 1'b0;
    if (!c && op == 4'd7) hi_m = v;
    if (!c && op == 4'd8) lo_m = v;
    check("move_busy", 32'(busy), 32'd0);
    check("move_hi", hi, hi_m);
    check("move_lo", lo, lo_m);
  endtask

  initial begin
    int n;
    logic [3:0] rop;
    reset = 1'b1; md_op = 4'd0; cancel = 1'b0; rs_val = 32'h0; rt_val = 32'h0;
    hi_m = 32'h0; lo_m = 32'h0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(negedge clk); reset = 1'b0;

    // Directed vectors.
    run_md(4'd1, 32'd7, 32'hFFFFFFFD, 5, 1'b0);
    check("mult_hi_const", hi, 32'hFFFFFFFF);
    check("mult_lo_const", lo, 32'hFFFFFFEB);
    run_md(4'd2, 32'hFFFFFFFF, 32'd2, 5, 1'b1);
    check("multu_lo_const", lo, 32'hFFFFFFFE);
    run_md(4'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b1);
    check("div_lo_const", lo, 32'hFFFFFFFD);
    check("div_hi_const", hi, 32'hFFFFFFFF);
    run_md(4'd4, 32'd7, 32'd2, 10, 1'b0);
    check("divu_lo_const", lo, 32'd3);
    move_to(4'd7, 32'h1234, 1'b0);
    run_md(4'd4, 32'd99, 32'd0, 10, 1'b0);
    check("div0_hi_const", hi, 32'h1234);
    run_md(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0);
    check("ovf_lo_const", lo, 32'h80000000);
    check("ovf_hi_const", hi, 32'h0);
    run_md(4'd3, 32'd7, 32'hFFFFFFFE, 10, 1'b0);

    // Cancelled start and cancelled mtlo.
    @(negedge clk);
    md_op = 4'd1; rs_val = 32'd3; rt_val = 32'd4; cancel = 1'b1;
    #1 check("start_cancel", 32'(start), 32'd0);
    @(posedge clk); #1;
    md_op = 4'd0; cancel = 1'b0;
    check("busy_cancel", 32'(busy), 32'd0);
    check("hi_cancel", hi, hi_m);
    check("lo_cancel", lo, lo_m);
    move_to(4'd8, 32'hAA, 1'b1);
    move_to(4'd8, 32'hAA, 1'b0);
    md_op = 4'd9;
    #1 check("md_out_none", md_out, 32'h0);
    md_op = 4'd0;

    // Random operations.
    for (int i = 0; i < 12; i++) begin
      rop = 4'($urandom_range(1, 4));
      run_md(rop, $urandom, (i % 4 == 3) ? 32'($urandom_range(0, 3)) : $urandom,
             (rop <= 4'd2) ? 5 : 10, 1'(i % 2));
    end

    // Reset in busy cycle 3 aborts the multiply.
    @(negedge clk);
    md_op = 4'd1; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk); #1;
    md_op = 4'd0;
    n = 0;
    while (n < 2) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_before_rst", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    @(negedge clk); reset = 1'b0;
    hi_m = 32'h0; lo_m = 32'h0;
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;
    check("rst_late_busy", 32'(busy), 32'd0);
    check("rst_late_hi", hi, 32'h0);
    check("rst_late_lo", lo, 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
